// File: rtl/uart_pkg.sv
// Shared types for the framed UART transmitter: FSM states, parity mode
// encodings and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3
  } par_mode_t;

  localparam int unsigned MAX_DATA_W = 9;

  // Payload is zero-extended to MAX_DATA_W, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input logic                  odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick
// on the final cycle of each bit period.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned    CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: start bit, LSB-first payload, optional parity,
// one or two stop bits. Frame settings are latched at accept.
//
// state     | meaning
// ST_IDLE   | line high, tx_ready=1, waiting for tx_valid
// ST_START  | driving the start bit (0)
// ST_DATA   | shifting payload bits, LSB first
// ST_PARITY | driving the even/odd parity bit
// ST_STOP   | driving one or two stop bits (1)
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        par_mode,
  input  logic              stop2,
  output logic              txd,
  output logic              busy
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W);

  state_t              state_q;
  logic [DATA_W-1:0]   shift_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic                par_en_q;
  logic                par_bit_q;
  logic                stop2_q;
  logic                txd_q;
  logic                ready_q;

  logic                accept;
  logic                tick;
  logic [MAX_DATA_W-1:0] data_ext;

  assign accept = tx_valid && ready_q;

  always_comb begin
    data_ext = '0;
    data_ext[DATA_W-1:0] = tx_data;
  end

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .enable(state_q != ST_IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
      ready_q   <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q   <= ST_START;
            shift_q   <= tx_data;
            bit_cnt_q <= '0;
            par_en_q  <= (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
            par_bit_q <= parity_bit(data_ext, par_mode == PAR_ODD);
            stop2_q   <= stop2;
            txd_q     <= 1'b0;
            ready_q   <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state_q   <= ST_DATA;
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= BIT_W'(1);
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt_q != LAST_BIT) begin
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end else if (par_en_q) begin
              state_q <= ST_PARITY;
              txd_q   <= par_bit_q;
            end else begin
              state_q   <= ST_STOP;
              txd_q     <= 1'b1;
              bit_cnt_q <= '0;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q   <= ST_STOP;
            txd_q     <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        ST_STOP: begin
          // bit_cnt_q is reused here to count the first of two stop bits
          if (tick) begin
            if (stop2_q && (bit_cnt_q == '0)) begin
              bit_cnt_q <= BIT_W'(1);
            end else begin
              state_q   <= ST_IDLE;
              bit_cnt_q <= '0;
              txd_q     <= 1'b1;
              ready_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 1'b1;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign tx_ready = ready_q;
  assign busy     = ~ready_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx (DATA_W=8, CLKS_PER_BIT=4) against a
// bit-list frame model built from the framing rules.
module tb_uart_frame_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [1:0]    par_mode;
  logic          stop2;
  logic          txd;
  logic          busy;

  int checks;
  int errors;

  logic exp_bits [0:11];
  int   exp_n;

  uart_frame_tx #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .par_mode(par_mode),
    .stop2   (stop2),
    .txd     (txd),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame model: start, LSB-first data, optional parity, one or two stops.
  task automatic build_frame(input logic [DW-1:0] d, input logic [1:0] m,
                             input logic s2);
    int n;
    int ones;
    n = 0;
    ones = 0;
    exp_bits[n] = 1'b0; n++;
    for (int i = 0; i < DW; i++) begin
      exp_bits[n] = d[i]; n++;
      if (d[i]) ones++;
    end
    if (m == 2'd1) begin
      exp_bits[n] = ((ones % 2) == 1); n++;
    end else if (m == 2'd2) begin
      exp_bits[n] = ((ones % 2) == 0); n++;
    end
    exp_bits[n] = 1'b1; n++;
    if (s2) begin
      exp_bits[n] = 1'b1; n++;
    end
    exp_n = n;
  endtask

  // Entered at the negedge where the start bit must be visible; returns on
  // the negedge following the last bit period.
  task automatic check_frame(input string name, input int pulse_at,
                             input bit hold);
    int cyc;
    cyc = 0;
    for (int b = 0; b < exp_n; b++) begin
      for (int c = 0; c < CPB; c++) begin
        checks++;
        if (txd !== exp_bits[b] || busy !== 1'b1 || tx_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s bit%0d cyc%0d: txd=%b busy=%b rdy=%b, required txd=%b busy=1 rdy=0",
                   name, b, c, txd, busy, tx_ready, exp_bits[b]);
        end
        if (!hold) begin
          tx_valid = (cyc == pulse_at) || (cyc == pulse_at + 1);
          tx_data  = DW'($urandom);
          par_mode = 2'($urandom);
          stop2    = 1'($urandom);
        end
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: txd=%b busy=%b rdy=%b, required txd=1 busy=0 rdy=1",
               name, txd, busy, tx_ready);
    end
  endtask

  // Offer a frame at a negedge; after the accepting posedge the inputs are
  // scrambled so any late sampling would corrupt the frame.
  task automatic start_frame(input logic [DW-1:0] d, input logic [1:0] m,
                             input logic s2, input bit hold);
    tx_data  = d;
    par_mode = m;
    stop2    = s2;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    tx_data  = DW'($urandom);
    par_mode = 2'($urandom);
    stop2    = 1'($urandom);
  endtask

  task automatic send(input string name, input logic [DW-1:0] d,
                      input logic [1:0] m, input logic s2);
    check_idle({name, "_pre"});
    build_frame(d, m, s2);
    start_frame(d, m, s2, 1'b0);
    check_frame(name, -10, 1'b0);
    check_idle({name, "_post"});
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    par_mode = 2'd1;
    stop2    = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_held");
    tx_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_directed();
    send("a5_even_1stop", 8'hA5, 2'd1, 1'b0);
    send("a5_odd_2stop",  8'hA5, 2'd2, 1'b1);
    send("00_none_1stop", 8'h00, 2'd0, 1'b0);
    send("ff_mode3_2stop", 8'hFF, 2'd3, 1'b1);
    send("01_odd_1stop",  8'h01, 2'd2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      send($sformatf("rand%0d", i), DW'($urandom), 2'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    check_idle("b2b_pre");
    build_frame(8'h3C, 2'd1, 1'b0);
    start_frame(8'h3C, 2'd1, 1'b0, 1'b1);
    tx_data  = 8'hC3;
    par_mode = 2'd0;
    stop2    = 1'b1;
    check_frame("b2b_first", -10, 1'b1);
    check_idle("b2b_gap");
    @(negedge clk);
    tx_valid = 1'b0;
    build_frame(8'hC3, 2'd0, 1'b1);
    check_frame("b2b_second", -10, 1'b0);
    check_idle("b2b_post");
  endtask

  task automatic test_busy_ignore();
    build_frame(8'h96, 2'd2, 1'b0);
    start_frame(8'h96, 2'd2, 1'b0, 1'b0);
    check_frame("busy_pulse", 13, 1'b0);
    for (int i = 0; i < 3 * CPB * 12; i++) begin
      check_idle($sformatf("busy_after%0d", i));
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    build_frame(8'h00, 2'd0, 1'b0);
    start_frame(8'h00, 2'd0, 1'b0, 1'b0);
    repeat (3 * CPB + 1) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_run: busy=%b, required 1", busy);
      end
      @(negedge clk);
    end
    checks++;
    if (txd !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_bit3: txd=%b, required 0", txd);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("rst_mid_abort");
    rst_n = 1'b1;
    for (int i = 0; i < 12 * CPB; i++) begin
      @(negedge clk);
      check_idle($sformatf("rst_mid_after%0d", i));
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    par_mode = '0;
    stop2    = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    send("after_reset", 8'h5A, 2'd1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame, legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit, minimum 2.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 tx_data  input  DATA_W  payload, sampled on accept.
REQ-007 tx_valid  input  1  payload offered.
REQ-008 tx_ready  output  1  block can accept a frame this cycle.
REQ-009 par_mode  input  2  sampled on accept: 0 none, 1 even, 2 odd, 3 treated as none.
REQ-010 stop2  input  1  sampled on accept: 0 one stop bit, 1 two stop bits.
REQ-011 txd  output  1  serial line, idle high.
REQ-012 busy  output  1  high while a frame is being shifted out.

Function
REQ-013 Accept SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; tx_data, par_mode and stop2 are latched then; later input changes do not affect the frame in flight.
REQ-014 tx_ready SHALL be 1 only in IDLE; tx_valid while busy is ignored and not queued.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START on accept, START->DATA, DATA->PARITY after DATA_W bits if parity enabled else DATA->STOP, PARITY->STOP, STOP->IDLE after 1 or 2 stop bits.
REQ-016 Each non-IDLE bit SHALL be held on txd for exactly CLKS_PER_BIT cycles, timed by a baud counter counting 0..CLKS_PER_BIT-1 and cleared on accept.
REQ-017 txd SHALL go low (start bit) on the edge following accept, i.e. one-cycle latency.
REQ-018 Data bits SHALL be sent LSB first.
REQ-019 Parity bit SHALL be XOR of the latched data for even mode and its inverse for odd mode.
REQ-020 Stop bits and IDLE SHALL drive txd=1.
REQ-021 Frame length in bits SHALL be 1 + DATA_W + (parity enabled ? 1 : 0) + (stop2 ? 2 : 1); busy is high for exactly that many bits times CLKS_PER_BIT cycles.
REQ-022 After the last stop-bit cycle the FSM SHALL return to IDLE, giving at least one cycle of tx_ready=1 between frames; back-to-back frames are separated by exactly one idle clk when tx_valid is held high.
REQ-023 busy SHALL equal the inverse of tx_ready at all times.

Reset
REQ-024 While rst_n=0 at a rising edge, state SHALL become IDLE, txd=1, busy=0, tx_ready=1, baud and bit counters 0, latched data/mode 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with txd=1 from the next edge; no partial frame resumes after release.
REQ-026 An accept SHALL NOT occur on any edge where rst_n=0.

Structure
REQ-027 A shared package uart_pkg SHALL hold the FSM state enum and the par_mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-028 The baud counter SHALL be a sub-module uart_baud_tick (parameter CLKS_PER_BIT, inputs clk, rst_n, clear, enable; output tick pulsing on the last cycle of each bit period).
REQ-029 Bit counter width SHALL be $clog2(DATA_W+1); baud counter width $clog2(CLKS_PER_BIT).

Verification (DATA_W=8, CLKS_PER_BIT=4)
REQ-030 Send 0xA5, par_mode=1, stop2=0 -> txd bit sequence 0,1,0,1,0,0,1,0,1,0,1, each 4 cycles; busy high 44 cycles.
REQ-031 Send 0xA5, par_mode=2, stop2=1 -> parity bit 1, two stop bits; busy high 48 cycles.
REQ-032 Send 0x00, par_mode=0, stop2=0 -> txd low 36 cycles then high; busy high 40 cycles.
REQ-033 Hold tx_valid=1 with 0x3C then 0xC3 -> second start bit begins exactly one cycle after first frame's busy falls; tx_data change during frame 1 does not corrupt it.
REQ-034 Assert rst_n=0 during bit 3 of a frame -> txd=1, busy=0, tx_ready=1 on next edge; line stays high after release until a new accept.
REQ-035 Pulse tx_valid while busy -> ignored; no extra frame transmitted.
